// File: rtl/digit_cnt_pkg.sv
// Shared types and helpers for the multi-digit increment counter.
// Optional feature macro used by the counter top: CNT_SNAPSHOT_EN.
package digit_cnt_pkg;

    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } cnt_state_e;

    // A digit passes the carry on only when it is at its maximum value.
    function automatic logic digit_all_ones(input logic [DIGIT_W-1:0] d);
        return &d;
    endfunction

endpackage

// File: rtl/digit_incr2.sv
// Combinational 2-bit increment cell: adds en_i to the digit and
// raises cout_o when an enabled increment rolls the digit over.
module digit_incr2
    import digit_cnt_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    input  logic               en_i,
    output logic [DIGIT_W-1:0] sum_o,
    output logic               cout_o
);

    // Increment the digit when enabled; carry out on an all-ones digit.
    always_comb begin
        sum_o  = d_i + {{(DIGIT_W-1){1'b0}}, en_i};
        cout_o = en_i & digit_all_ones(d_i);
    end

endmodule

// File: rtl/digit_incr_counter.sv
// Registered multi-digit counter built from digit_incr2 cells, with a
// valid/ready increment port, parallel load, overflow flags and a
// run/halt state machine.
// Optional: define CNT_SNAPSHOT_EN to add snap_req/snap_count.
module digit_incr_counter
    import digit_cnt_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter bit          WRAP       = 1'b1,
    localparam int unsigned CW        = DIGIT_W * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          clr,
    input  logic          inc_valid,
    output logic          inc_ready,
    input  logic          load_valid,
    input  logic [CW-1:0] load_data,
    output logic [CW-1:0] count,
    output logic          ovf_pulse,
    output logic          ovf_sticky,
    output logic [1:0]    state_o
`ifdef CNT_SNAPSHOT_EN
    ,
    input  logic          snap_req,
    output logic [CW-1:0] snap_count
`endif
);

    cnt_state_e          state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic                sticky_q, sticky_d;
    logic                pulse_q, pulse_d;
    logic [CW-1:0]       sum;
    logic [NUM_DIGITS:0] carry;
    logic                xfer;
    logic                ovf;

    assign inc_ready  = (state_q == RUN) & ~load_valid & ~clr;
    assign xfer       = inc_valid & inc_ready;
    assign carry[0]   = xfer;
    assign ovf        = carry[NUM_DIGITS];
    assign count      = count_q;
    assign ovf_pulse  = pulse_q;
    assign ovf_sticky = sticky_q;
    assign state_o    = state_q;

    // Each cell is enabled by the carry of the digits below it, so digit k
    // only moves when digits 0..k-1 are all ones.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        digit_incr2 u_cell (
            .d_i    (count_q[g*DIGIT_W +: DIGIT_W]),
            .en_i   (carry[g]),
            .sum_o  (sum[g*DIGIT_W +: DIGIT_W]),
            .cout_o (carry[g+1])
        );
    end

    // Next-state: clr > load > increment for the datapath, then the FSM
    // with stop overriding every other transition.
    always_comb begin
        count_d  = count_q;
        sticky_d = sticky_q;
        pulse_d  = 1'b0;
        state_d  = state_q;

        if (clr) begin
            count_d  = '0;
            sticky_d = 1'b0;
            if (state_q == HALT) state_d = RUN;
        end else if (load_valid) begin
            count_d = load_data;
            if (state_q == HALT) state_d = RUN;
        end else if (ovf) begin
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            if (WRAP) begin
                count_d = sum;
            end else begin
                count_d = count_q;
                state_d = HALT;
            end
        end else if (xfer) begin
            count_d = sum;
        end

        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            default: if (stop) state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sticky_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef CNT_SNAPSHOT_EN
    logic [CW-1:0] snap_q;

    assign snap_count = snap_q;

    // Capture the pre-update count, independent of load/clr/increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else if (snap_req) begin
            snap_q <= count_q;
        end
    end
`endif

endmodule
